upsample_pad_stream: RTL and testbench
======================================

Name: upsample_pad_stream

Overview:
- Parametrised streaming front-end for transposed-conv layers.
- Takes an IN_W x IN_H frame in raster order, inserts STRIDE-1 zeros between samples in both axes, and adds a PAD-wide zero border.
- Emits the expanded frame in raster order to a downstream conv window, with full ready/valid backpressure on both sides.
- Flushes trailing zero rows and columns itself; no dummy input is needed at end of frame.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement).
- IN_W, 16, input frame width in samples (>=1).
- IN_H, 16, input frame height in samples (>=1).
- STRIDE, 2, upsample factor (>=1; 1 gives padding only).
- PAD, 2, zero border width on each side (>=0).
- Derived, not overridable: OW = (IN_W-1)*STRIDE+1+2*PAD; OH = (IN_H-1)*STRIDE+1+2*PAD.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- valid_in  in  1  upstream sample valid.
- data_in  in  DATA_WIDTH  upstream sample.
- ready_out  out  1  block accepts data_in this cycle.
- valid_out  out  1  data_out valid.
- data_out  out  DATA_WIDTH  expanded-frame sample.
- ready_in  in  1  downstream accepts data_out this cycle.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: valid_out=0, data_out=0, ready_out=0, busy=0, state=IDLE, ox=oy=0.
- Reset wins over every other event and aborts a frame mid-stream. The partial frame is discarded and no remaining zeros are emitted.
- Output register: loads when (!valid_out || ready_in). If valid_out && !ready_in, data_out and valid_out hold stable.
- Position (ox,oy) is a sample position iff ox>=PAD, ox<OW-PAD, (ox-PAD)%STRIDE==0, and the same three conditions hold for oy. Every other position is a zero position.
- FSM states:
  - IDLE: ready_out=0. When valid_in=1 (sample not consumed), go to RUN next cycle with ox=oy=0.
  - RUN, zero position: when the output register can load, load 0, set valid_out=1, advance ox,oy. No upstream handshake.
  - RUN, sample position: ready_out = (!valid_out || ready_in). On valid_in && ready_out, load data_in, set valid_out=1, advance. Otherwise stall; ox,oy hold.
  - Advance rule: ox wraps OW-1 -> 0 and increments oy. After (OW-1,OH-1) is loaded, return to IDLE.
- Latency: accepted sample appears on data_out the next cycle.
- Throughput: one output per cycle while ready_in=1 and upstream keeps up.
- ready_out is combinational from state, position and output-register state, never from valid_in. ready_in may combinationally affect ready_out.
- Frame totals: exactly OW*OH outputs and IN_W*IN_H accepted samples per frame.
- Trailing PAD zero rows are emitted without input.
- Back-to-back frames: the next frame starts from IDLE. One bubble cycle between frames is allowed.
- busy = (state==RUN) || valid_out.
- Samples pass bit-exact; no arithmetic on data.
- Counters sized $clog2(OW+1) and $clog2(OH+1).

Optional Feature:
- Macro UPS_FRAME_MARK_EN.
- Defined: adds outputs eol_out (1 bit, high with the sample at ox==OW-1) and eof_out (1 bit, high with the sample at (OW-1,OH-1)).
  - Both are registered alongside data_out and share its hold and reset (0) rules.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- IN_W=2, IN_H=2, STRIDE=2, PAD=1; input 5,6,7,8; ready_in=1 -> 25 outputs.
  - Rows: 0 0 0 0 0 / 0 5 0 6 0 / 0 0 0 0 0 / 0 7 0 8 0 / 0 0 0 0 0.
  - busy falls after the last zero with no further input.
- Defaults (16x16, S=2, P=2); input 1..256 -> exactly 1225 outputs.
  - Output index 2*35+2 = 1; the final 2 rows (70 outputs) are all 0.
  - No extra valid_in is required.
- Same as the first case with ready_in toggled 1,0,0,1 repeating -> identical 25-value sequence.
  - data_out is stable during every ready_in=0 cycle.
  - ready_out is never high while valid_out && !ready_in.
- Same as the first case with valid_in gapped every other cycle -> identical sequence; zero positions do not advance past an unavailable sample.
- Assert rst_n=0 for 1 cycle after the 7th output, then send a full new frame 1,2,3,4.
  - Cycle after reset: valid_out=0, busy=0.
  - Next frame output equals the first-case pattern with 1,2,3,4 substituted.
- With UPS_FRAME_MARK_EN, first-case stimulus -> eol_out high on outputs 5,10,15,20,25; eof_out high only on output 25.

Source files
------------

// File: rtl/upsample_pad_stream_if.sv
// Stream bundle for upsample_pad_stream.
//   slave  : block side (consumes valid_in/data_in/ready_in, drives the rest)
//   master : environment side (drives valid_in/data_in/ready_in)
// Signals: valid_in, data_in, ready_out (upstream handshake);
//          valid_out, data_out, ready_in (downstream handshake); busy.
// Optional macro UPS_FRAME_MARK_EN adds eol_out / eof_out frame markers.
interface upsample_pad_stream_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_out;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready_in;
  logic                  busy;
`ifdef UPS_FRAME_MARK_EN
  logic                  eol_out;
  logic                  eof_out;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, busy, eol_out, eof_out
  );
  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, busy, eol_out, eof_out
  );
`else
  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, busy
  );
  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, busy
  );
`endif
endinterface

// File: rtl/upsample_pad_stream.sv
// upsample_pad_stream: zero-insertion upsampler with zero border for
// transposed-conv front-ends. Takes an IN_W x IN_H raster frame, inserts
// STRIDE-1 zeros between samples in both axes, surrounds the result with a
// PAD-wide zero border and emits the OW x OH frame in raster order.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus    - upsample_pad_stream_if.slave (valid_in/data_in/ready_out upstream,
//            valid_out/data_out/ready_in downstream, busy)
// Optional macro UPS_FRAME_MARK_EN: adds registered eol_out/eof_out markers.
module upsample_pad_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_W       = 16,
  parameter int unsigned IN_H       = 16,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned PAD        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  upsample_pad_stream_if.slave  bus
);

  localparam int unsigned OW = (IN_W - 1) * STRIDE + 1 + 2 * PAD;
  localparam int unsigned OH = (IN_H - 1) * STRIDE + 1 + 2 * PAD;
  localparam int unsigned XW = $clog2(OW + 1);
  localparam int unsigned YW = $clog2(OH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         ox_q, ox_d;
  logic [YW-1:0]         oy_q, oy_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;

  logic                  can_load;
  logic                  ready_out_c;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_val;
  logic [31:0]           ox_i, oy_i;
  logic                  x_smp, y_smp;
  logic                  at_eol, at_last_row;

  // The output register may take a new value when it is empty or being drained.
  assign can_load = !valid_out_q || bus.ready_in;

  // Sample-position decode. The subtraction underflows for positions inside
  // the leading border, but the >= PAD term masks that case.
  always_comb begin
    ox_i        = 32'(ox_q);
    oy_i        = 32'(oy_q);
    x_smp       = (ox_i >= PAD) && (ox_i < OW - PAD) && (((ox_i - PAD) % STRIDE) == 0);
    y_smp       = (oy_i >= PAD) && (oy_i < OH - PAD) && (((oy_i - PAD) % STRIDE) == 0);
    at_eol      = (ox_q == XW'(OW - 1));
    at_last_row = (oy_q == YW'(OH - 1));
  end

  always_comb begin
    state_d     = state_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    ready_out_c = 1'b0;
    load        = 1'b0;
    load_val    = '0;

    // Current word leaves (or slot was empty); refilled below if we load.
    if (can_load) begin
      valid_out_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // valid_in only wakes the block; the sample is taken in RUN.
        if (bus.valid_in) begin
          state_d = RUN;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      RUN: begin
        if (x_smp && y_smp) begin
          ready_out_c = can_load;
          if (bus.valid_in && can_load) begin
            load     = 1'b1;
            load_val = bus.data_in;
          end
        end else if (can_load) begin
          load     = 1'b1;
          load_val = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_out_d = 1'b1;
      data_out_d  = load_val;
      eol_d       = at_eol;
      eof_d       = at_eol && at_last_row;
      if (at_eol) begin
        ox_d = '0;
        if (at_last_row) begin
          oy_d    = '0;
          state_d = IDLE;
        end else begin
          oy_d = oy_q + YW'(1);
        end
      end else begin
        ox_d = ox_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.ready_out = ready_out_c;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.busy      = (state_q == RUN) || valid_out_q;

`ifdef UPS_FRAME_MARK_EN
  assign bus.eol_out = eol_q;
  assign bus.eof_out = eof_q;
`else
  // Markers are tracked regardless; without the ports they have no reader.
  logic unused_marks;
  assign unused_marks = eol_q ^ eof_q;
`endif

endmodule

// File: tb/tb_upsample_pad_stream.sv
module tb_upsample_pad_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_in;
  int          sel;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  upsample_pad_stream_if #(.DATA_WIDTH(16)) bus_s ();
  upsample_pad_stream_if #(.DATA_WIDTH(16)) bus_d ();

  upsample_pad_stream #(
    .DATA_WIDTH(16), .IN_W(2), .IN_H(2), .STRIDE(2), .PAD(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
  );

  upsample_pad_stream #(
    .DATA_WIDTH(16), .IN_W(16), .IN_H(16), .STRIDE(2), .PAD(2)
  ) dut_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d.slave)
  );

  assign bus_s.valid_in = (sel == 0) ? valid_in : 1'b0;
  assign bus_s.data_in  = data_in;
  assign bus_s.ready_in = (sel == 0) ? ready_in : 1'b1;
  assign bus_d.valid_in = (sel == 1) ? valid_in : 1'b0;
  assign bus_d.data_in  = data_in;
  assign bus_d.ready_in = (sel == 1) ? ready_in : 1'b1;

  logic        o_valid, o_ready, o_busy;
  logic [15:0] o_data;
  assign o_valid = (sel == 0) ? bus_s.valid_out : bus_d.valid_out;
  assign o_ready = (sel == 0) ? bus_s.ready_out : bus_d.ready_out;
  assign o_busy  = (sel == 0) ? bus_s.busy      : bus_d.busy;
  assign o_data  = (sel == 0) ? bus_s.data_out  : bus_d.data_out;
`ifdef UPS_FRAME_MARK_EN
  logic o_eol, o_eof;
  assign o_eol = (sel == 0) ? bus_s.eol_out : bus_d.eol_out;
  assign o_eof = (sel == 0) ? bus_s.eof_out : bus_d.eof_out;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: map each output coordinate back to an input index.
  function automatic void build_exp(input int inw, input int inh, input int st, input int pd,
                                    input logic [15:0] src[$], output logic [15:0] e[$]);
    int ow, oh, rx, ry;
    ow = (inw - 1) * st + 1 + 2 * pd;
    oh = (inh - 1) * st + 1 + 2 * pd;
    e.delete();
    for (int y = 0; y < oh; y++) begin
      for (int x = 0; x < ow; x++) begin
        rx = x - pd;
        ry = y - pd;
        if (rx >= 0 && ry >= 0 && rx % st == 0 && ry % st == 0 &&
            rx / st < inw && ry / st < inh)
          e.push_back(src[(ry / st) * inw + rx / st]);
        else
          e.push_back(16'd0);
      end
    end
  endfunction

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  // vmode: 0 valid whenever data remains, 1 every other cycle, 2 random.
  // abort_at > 0: pulse reset after that many outputs and stop.
  task automatic run_frame(input int s, input string nm, input logic [15:0] src[$],
                           input int rmode, input int vmode, input int abort_at,
                           output logic [15:0] got[$]);
    int inw, inh, st, pd, ow, oh, total, ip, oc, cyc, rph;
    logic gate, prev_stall;
    logic [15:0] prev_data;
    logic [15:0] e[$];
    inw = (s == 0) ? 2 : 16;
    inh = inw;
    st  = 2;
    pd  = (s == 0) ? 1 : 2;
    ow  = (inw - 1) * st + 1 + 2 * pd;
    oh  = (inh - 1) * st + 1 + 2 * pd;
    total = ow * oh;
    build_exp(inw, inh, st, pd, src, e);
    sel = s;
    got.delete();
    ip = 0; oc = 0; cyc = 0; rph = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (cyc > 20000) begin
        chk({nm, "_timeout"}, 32'(oc), 32'(total));
        valid_in = 1'b0;
        ready_in = 1'b1;
        return;
      end
      cyc++;
      case (rmode)
        0:       ready_in = 1'b1;
        1:       begin ready_in = (rph % 4 == 0) || (rph % 4 == 3); rph++; end
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      case (vmode)
        0:       gate = 1'b1;
        1:       gate = (cyc % 2 == 0);
        default: gate = ($urandom_range(0, 3) != 0);
      endcase
      if (ip < src.size() && gate) begin
        valid_in = 1'b1;
        data_in  = src[ip];
      end else begin
        valid_in = 1'b0;
        data_in  = 16'($urandom);
      end
      #1;
      if (prev_stall) begin
        chk({nm, "_hold_v"}, 32'(o_valid), 32'd1);
        chk({nm, "_hold_d"}, 32'(o_data), 32'(prev_data));
      end
      if (o_valid && !ready_in)
        chk({nm, "_rdy_bp"}, 32'(o_ready), 32'd0);
      if (o_valid && ready_in) begin
        if (oc < total) begin
          chk({nm, "_data"}, 32'(o_data), 32'(e[oc]));
`ifdef UPS_FRAME_MARK_EN
          chk({nm, "_eol"}, 32'(o_eol), 32'((oc % ow) == ow - 1));
          chk({nm, "_eof"}, 32'(o_eof), 32'(oc == total - 1));
`endif
        end else begin
          chk({nm, "_extra_out"}, 32'(oc), 32'(total - 1));
        end
        got.push_back(o_data);
        oc++;
      end
      if (valid_in && o_ready) ip++;
      prev_stall = o_valid && !ready_in;
      prev_data  = o_data;
      if (abort_at > 0 && oc == abort_at) begin
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({nm, "_rst_valid"}, 32'(o_valid), 32'd0);
        chk({nm, "_rst_busy"}, 32'(o_busy), 32'd0);
        chk({nm, "_rst_ready"}, 32'(o_ready), 32'd0);
        chk({nm, "_rst_data"}, 32'(o_data), 32'd0);
        return;
      end
      if (oc == total) begin
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk({nm, "_busy_end"}, 32'(o_busy), 32'd0);
        chk({nm, "_valid_end"}, 32'(o_valid), 32'd0);
        chk({nm, "_n_in"}, 32'(ip), 32'(inw * inh));
        chk({nm, "_n_out"}, 32'(oc), 32'(total));
        return;
      end
    end
  endtask

  initial begin
    logic [15:0] src[$];
    logic [15:0] got[$];
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    data_in  = '0;
    sel      = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
    end
    rst_n = 1'b1;

    src = '{16'd5, 16'd6, 16'd7, 16'd8};
    run_frame(0, "c1", src, 0, 0, 0, got);

    src.delete();
    for (int i = 1; i <= 256; i++) src.push_back(16'(i));
    run_frame(1, "dflt", src, 0, 0, 0, got);
    chk("dflt_idx72", (got.size() > 72) ? 32'(got[72]) : 32'hFFFF_FFFF, 32'd1);

    src.delete();
    for (int i = 0; i < 256; i++) src.push_back(16'($urandom));
    run_frame(1, "dflt_rnd", src, 2, 2, 0, got);

    src = '{16'd5, 16'd6, 16'd7, 16'd8};
    run_frame(0, "tgl", src, 1, 0, 0, got);
    run_frame(0, "gap", src, 0, 1, 0, got);
    run_frame(0, "abrt", src, 0, 0, 7, got);
    src = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_frame(0, "post", src, 0, 0, 0, got);

    for (int k = 0; k < 20; k++) begin
      src.delete();
      for (int i = 0; i < 4; i++) src.push_back(16'($urandom));
      run_frame(0, "rnd", src, 2, 2, 0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
